// File: rtl/solid_island_finder.sv
// solid_island_finder: queries every k-mer of a read against the membership table and
// reports the longest contiguous run of solid k-mers as an inclusive base-coordinate island.
// Ports:
//   clk, rstb                         clock, asynchronous active-low reset
//   i_read, i_quality, i_read_length  read bases (base i at [2i+1:2i]), qualities, length
//   i_kmer_length                     k, static while busy
//   i_read_valid / o_ready4read       read handshake (accepted only in IDLE)
//   o_kmer, o_kmer_valid, i_ready4kmer            query handshake to the table
//   i_query_result, i_query_result_valid          table answer (1 = solid)
//   o_read_out, o_quality_out, o_read_length_out  latched read data
//   o_start_position, o_end_position, o_island_found, o_num_solid  island result
//   o_out_valid / i_ready4island       result handshake
module solid_island_finder #(
    parameter int MAX_READ_BIT_WIDTH = 8,
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int MAX_READ_WIDTH     = 2 ** MAX_READ_BIT_WIDTH,
    parameter int MAX_KMER_WIDTH     = 2 ** MAX_KMER_BIT_WIDTH,
    parameter int QUALITY_WIDTH      = 2
) (
    input  logic                                      clk,
    input  logic                                      rstb,
    input  logic [2*MAX_READ_WIDTH-1:0]               i_read,
    input  logic [QUALITY_WIDTH*MAX_READ_WIDTH-1:0]   i_quality,
    input  logic [MAX_READ_BIT_WIDTH-1:0]             i_read_length,
    input  logic [MAX_KMER_BIT_WIDTH-1:0]             i_kmer_length,
    input  logic                                      i_read_valid,
    output logic                                      o_ready4read,
    output logic [2*MAX_KMER_WIDTH-1:0]               o_kmer,
    output logic                                      o_kmer_valid,
    input  logic                                      i_ready4kmer,
    input  logic                                      i_query_result,
    input  logic                                      i_query_result_valid,
    output logic [2*MAX_READ_WIDTH-1:0]               o_read_out,
    output logic [QUALITY_WIDTH*MAX_READ_WIDTH-1:0]   o_quality_out,
    output logic [MAX_READ_BIT_WIDTH-1:0]             o_read_length_out,
    output logic [MAX_READ_BIT_WIDTH-1:0]             o_start_position,
    output logic [MAX_READ_BIT_WIDTH-1:0]             o_end_position,
    output logic                                      o_island_found,
    output logic [MAX_READ_BIT_WIDTH-1:0]             o_num_solid,
    output logic                                      o_out_valid,
    input  logic                                      i_ready4island
);
    localparam int RB = MAX_READ_BIT_WIDTH;
    localparam int KB = MAX_KMER_BIT_WIDTH;
    localparam int LW = (RB > KB) ? RB : KB;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t                 r_state, w_next;
    logic [KB-1:0]          r_kmer_len;
    logic [RB-1:0]          r_p, r_run_start, r_best_start, r_best_end, r_best_len, r_num_solid;
    logic                   r_run_active;
    logic [RB-1:0]          w_klen, w_last_p, w_run_start, w_run_len;
    logic                   w_short, w_found;
    logic [2*MAX_KMER_WIDTH-1:0] w_kmer;

    assign w_klen      = RB'(r_kmer_len);
    assign w_last_p    = o_read_length_out - w_klen;
    assign w_short     = (LW'(i_read_length) < LW'(i_kmer_length)) || (i_kmer_length == '0);
    // a solid hit either extends the current run or opens a new one at p
    assign w_run_start = r_run_active ? r_run_start : r_p;
    assign w_run_len   = r_p - w_run_start + RB'(1);
    assign w_found     = r_best_len != '0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_read_valid ? (w_short ? S_OUT : S_ISSUE) : S_IDLE;
            S_ISSUE: w_next = i_ready4kmer ? S_WAIT : S_ISSUE;
            S_WAIT:  w_next = i_query_result_valid ? ((r_p == w_last_p) ? S_OUT : S_ISSUE) : S_WAIT;
            S_OUT:   w_next = i_ready4island ? S_IDLE : S_OUT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            o_read_out        <= '0;
            o_quality_out     <= '0;
            o_read_length_out <= '0;
            r_kmer_len        <= '0;
            r_p               <= '0;
            r_run_active      <= 1'b0;
            r_run_start       <= '0;
            r_best_start      <= '0;
            r_best_end        <= '0;
            r_best_len        <= '0;
            r_num_solid       <= '0;
        end else if (r_state == S_IDLE && i_read_valid) begin
            o_read_out        <= i_read;
            o_quality_out     <= i_quality;
            o_read_length_out <= i_read_length;
            r_kmer_len        <= i_kmer_length;
            r_p               <= '0;
            r_run_active      <= 1'b0;
            r_run_start       <= '0;
            r_best_start      <= '0;
            r_best_end        <= '0;
            r_best_len        <= '0;
            r_num_solid       <= '0;
        end else if (r_state == S_WAIT && i_query_result_valid) begin
            if (i_query_result) begin
                r_num_solid  <= r_num_solid + RB'(1);
                r_run_active <= 1'b1;
                r_run_start  <= w_run_start;
                // strict compare keeps the earliest of equally long runs
                if (w_run_len > r_best_len) begin
                    r_best_start <= w_run_start;
                    r_best_end   <= r_p;
                    r_best_len   <= w_run_len;
                end
            end else begin
                r_run_active <= 1'b0;
            end
            if (r_p != w_last_p)
                r_p <= r_p + RB'(1);
        end
    end

    // k-mer window: bases p..p+k-1, zero past k and past the end of the read vector
    always_comb begin
        w_kmer = '0;
        for (int j = 0; j < MAX_KMER_WIDTH; j++)
            if (j < int'(r_kmer_len) && int'(r_p) + j < MAX_READ_WIDTH)
                w_kmer[2*j +: 2] = o_read_out[2*(int'(r_p) + j) +: 2];
    end

    assign o_ready4read     = r_state == S_IDLE;
    assign o_kmer_valid     = r_state == S_ISSUE;
    assign o_out_valid      = r_state == S_OUT;
    assign o_kmer           = o_kmer_valid ? w_kmer : '0;
    assign o_island_found   = o_out_valid && w_found;
    assign o_start_position = o_island_found ? r_best_start : '0;
    assign o_end_position   = !o_out_valid ? '0 :
                              w_found ? r_best_end + w_klen - RB'(1) : o_read_length_out - RB'(1);
    assign o_num_solid      = r_num_solid;
endmodule

// File: tb/tb_solid_island_finder.sv
// tb_solid_island_finder: table-driven, scoreboard-checked bench for solid_island_finder.
module tb_solid_island_finder;
    localparam int RB = 8, KB = 6, MRW = 256, MKW = 64, QW = 2;

    logic                  clk = 1'b0, rstb = 1'b0;
    logic [2*MRW-1:0]      i_read = '0;
    logic [QW*MRW-1:0]     i_quality = '0;
    logic [RB-1:0]         i_read_length = '0;
    logic [KB-1:0]         i_kmer_length = '0;
    logic                  i_read_valid = 1'b0, i_ready4kmer = 1'b0, i_query_result = 1'b0;
    logic                  i_query_result_valid = 1'b0, i_ready4island = 1'b0;
    logic                  o_ready4read, o_kmer_valid, o_island_found, o_out_valid;
    logic [2*MKW-1:0]      o_kmer;
    logic [2*MRW-1:0]      o_read_out;
    logic [QW*MRW-1:0]     o_quality_out;
    logic [RB-1:0]         o_read_length_out, o_start_position, o_end_position, o_num_solid;

    always #5 clk = ~clk;

    solid_island_finder dut (
        .clk(clk), .rstb(rstb), .i_read(i_read), .i_quality(i_quality),
        .i_read_length(i_read_length), .i_kmer_length(i_kmer_length),
        .i_read_valid(i_read_valid), .o_ready4read(o_ready4read), .o_kmer(o_kmer),
        .o_kmer_valid(o_kmer_valid), .i_ready4kmer(i_ready4kmer),
        .i_query_result(i_query_result), .i_query_result_valid(i_query_result_valid),
        .o_read_out(o_read_out), .o_quality_out(o_quality_out),
        .o_read_length_out(o_read_length_out), .o_start_position(o_start_position),
        .o_end_position(o_end_position), .o_island_found(o_island_found),
        .o_num_solid(o_num_solid), .o_out_valid(o_out_valid), .i_ready4island(i_ready4island)
    );

    typedef struct {
        int len; int k; logic [15:0] res; int kstall_q; int ostall; logic noise;
        int e_start; int e_end; logic e_found; int e_ns; int e_cyc; int e_nq;
    } vec_t;
    typedef struct { int s; int e; logic f; int ns; int cyc; int nq; } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_fail = 0;
    logic [2*MRW-1:0] rd;
    logic [QW*MRW-1:0] qd;
    vec_t tbl[10];

    task automatic chk(input string n, input logic [511:0] a, input logic [511:0] r);
        n_cmp++;
        if (a !== r) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, r);
        end
    endtask

    // independent reference: base i of the stimulus read is i%4
    function automatic logic [127:0] exp_kmer(input int p, input int k);
        logic [127:0] e = '0;
        for (int j = 0; j < k; j++)
            if (p + j < MRW) e[2*j +: 2] = 2'((p + j) % 4);
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t x;
        int c, q, held, oh, first;
        logic resp, done;
        sb.push_back('{v.e_start, v.e_end, v.e_found, v.e_ns, v.e_cyc, v.e_nq});
        for (int i = 0; i < 16; i++) qd[32*i +: 32] = $urandom;
        i_read = rd; i_quality = qd;
        i_read_length = RB'(v.len); i_kmer_length = KB'(v.k);
        i_read_valid = 1'b1; i_ready4kmer = 1'b1; i_ready4island = 1'b1;
        @(posedge clk); #1;
        i_read_valid = 1'b0;
        i_query_result_valid = v.noise; i_query_result = v.noise;
        c = 1; q = 0; held = 0; oh = 0; first = -1; resp = 1'b0; done = 1'b0;
        x = sb[0];
        while (!done && c < 400) begin
            @(negedge clk);
            i_ready4kmer = 1'b1;
            if (o_kmer_valid) begin
                chk("kmer", o_kmer, exp_kmer(q, v.k));
                if (v.k == 4 && q == 1) chk("kmer_p1", o_kmer, 128'h39);
                if (q == v.kstall_q && held < 5) begin
                    i_ready4kmer = 1'b0;
                    held++;
                end else resp = 1'b1;
            end
            if (o_out_valid) begin
                if (first < 0) begin
                    first = c;
                    chk("out_cycle", c, x.cyc);
                    chk("num_queries", q, x.nq);
                    chk("read_out", o_read_out, rd);
                    chk("quality_out", o_quality_out, qd);
                    chk("read_length_out", o_read_length_out, v.len);
                end
                chk("start", o_start_position, x.s);
                chk("end", o_end_position, x.e);
                chk("found", o_island_found, x.f);
                chk("num_solid", o_num_solid, x.ns);
                chk("ready4read_busy", o_ready4read, 0);
                if (oh < v.ostall) begin
                    i_ready4island = 1'b0;
                    oh++;
                end else begin
                    i_ready4island = 1'b1;
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
            c++;
            if (resp) begin
                i_query_result_valid = 1'b1;
                i_query_result = v.res[q];
                q++;
                resp = 1'b0;
            end else begin
                i_query_result_valid = v.noise;
                i_query_result = v.noise;
            end
        end
        void'(sb.pop_front());
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: no result after %0d cycles, required %0d", c, x.cyc);
        end
        i_query_result_valid = 1'b0; i_query_result = 1'b0;
        i_ready4kmer = 1'b1; i_ready4island = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < MRW; i++) rd[2*i +: 2] = 2'(i % 4);
        tbl[0] = '{10, 4, 16'h2E, -1, 0, 1'b0, 1, 6, 1'b1, 4, 15, 7};
        tbl[1] = '{10, 4, 16'h00, -1, 0, 1'b1, 0, 9, 1'b0, 0, 15, 7};
        tbl[2] = '{10, 4, 16'h1B, -1, 0, 1'b0, 0, 4, 1'b1, 4, 15, 7};
        tbl[3] = '{ 3, 4, 16'h00, -1, 0, 1'b0, 0, 2, 1'b0, 0,  1, 0};
        tbl[4] = '{10, 0, 16'h00, -1, 0, 1'b0, 0, 9, 1'b0, 0,  1, 0};
        tbl[5] = '{ 4, 4, 16'h01, -1, 0, 1'b0, 0, 3, 1'b1, 1,  3, 1};
        tbl[6] = '{10, 4, 16'h7F, -1, 0, 1'b0, 0, 9, 1'b1, 7, 15, 7};
        tbl[7] = '{10, 4, 16'h40, -1, 0, 1'b0, 6, 9, 1'b1, 1, 15, 7};
        tbl[8] = '{ 8, 3, 16'h1D, -1, 0, 1'b1, 2, 6, 1'b1, 4, 13, 6};
        tbl[9] = '{10, 4, 16'h2E,  1, 3, 1'b0, 1, 6, 1'b1, 4, 20, 7};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready4read", o_ready4read, 1);
        chk("rst_kmer_valid", o_kmer_valid, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_kmer", o_kmer, 0);
        chk("rst_found", o_island_found, 0);
        chk("rst_end", o_end_position, 0);
        chk("rst_num_solid", o_num_solid, 0);
        rstb = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // reset in the middle of a read while a query is outstanding
        i_read = rd; i_read_length = 8'd10; i_kmer_length = 6'd4;
        i_read_valid = 1'b1; i_ready4kmer = 1'b1;
        @(posedge clk); #1;
        i_read_valid = 1'b0;
        @(posedge clk); #1;
        i_query_result_valid = 1'b1; i_query_result = 1'b1;
        @(posedge clk); #1;
        i_query_result_valid = 1'b0;
        chk("ns_before_rst", o_num_solid, 1);
        @(posedge clk); #1;
        chk("in_wait_kmer_valid", o_kmer_valid, 0);
        rstb = 1'b0;
        #1;
        chk("midrst_ready4read", o_ready4read, 1);
        chk("midrst_kmer_valid", o_kmer_valid, 0);
        chk("midrst_num_solid", o_num_solid, 0);
        @(posedge clk); #1;
        rstb = 1'b1;
        i_query_result_valid = 1'b1; i_query_result = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stray_num_solid", o_num_solid, 0);
            chk("stray_ready4read", o_ready4read, 1);
            chk("stray_kmer_valid", o_kmer_valid, 0);
        end
        i_query_result_valid = 1'b0; i_query_result = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/solid_island_finder.md
# solid_island_finder

Scans every k-mer of an incoming read, queries each one against the k-mer membership table, and reports the longest contiguous run of solid (present) k-mers as a base-coordinate island `[startPosition, endPosition]`. It sits directly upstream of the first-k-mer corrector. It forwards the read, quality and length unchanged with the island bounds. A read with no solid k-mer is reported as `start=0, end=readLength-1`, which triggers first-k-mer correction downstream.

## Interface
Parameters:
- `MAX_READ_BIT_WIDTH`, default 8: position/length width.
- `MAX_KMER_BIT_WIDTH`, default 6: k-mer length width.
- `MAX_READ_WIDTH`, default `2**MAX_READ_BIT_WIDTH`: max bases per read.
- `MAX_KMER_WIDTH`, default `2**MAX_KMER_BIT_WIDTH`: max bases per k-mer.
- `QUALITY_WIDTH`, default 2: bits per quality value.

Ports:
- `clk`  in  1  clock.
- `rstb`  in  1  reset; asynchronous, active-low.
- `read`  in  `2*MAX_READ_WIDTH`  bases; base i at `[2i+1:2i]`.
- `quality`  in  `QUALITY_WIDTH*MAX_READ_WIDTH`  per-base quality.
- `readLength`  in  `MAX_READ_BIT_WIDTH`  bases in read.
- `kmerLength`  in  `MAX_KMER_BIT_WIDTH`  k; static while busy.
- `readValid`  in  1  input read offered.
- `ready4Read`  out  1  block idle; accepts read when high with `readValid`.
- `kmer`  out  `2*MAX_KMER_WIDTH`  query k-mer.
- `kmerValid`  out  1  query offered.
- `ready4Kmer`  in  1  table accepts query.
- `queryResult`  in  1  1 = solid.
- `queryResultValid`  in  1  result strobe.
- `readOut`, `qualityOut`, `readLengthOut`  out  same widths as inputs  latched read data.
- `startPosition`, `endPosition`  out  `MAX_READ_BIT_WIDTH`  island bounds, inclusive.
- `islandFound`  out  1  at least one solid k-mer.
- `numSolid`  out  `MAX_READ_BIT_WIDTH`  count of solid k-mers.
- `outValid`  out  1  result valid.
- `ready4Island`  in  1  downstream accepts result.

## Operation
- States: IDLE, ISSUE, WAIT_RESULT, OUT.
- **IDLE.** `ready4Read=1`. On `readValid`, latch all inputs and clear `p`, `runActive`, `runStart`, `bestStart`, `bestEnd`, `bestLen`, `numSolid`. Then:
  - if `readLength < kmerLength` or `kmerLength == 0`, go to OUT;
  - otherwise go to ISSUE.
- `lastP = readLength - kmerLength`.
- **ISSUE.** `kmerValid=1`.
  - `kmer` = latched `read` bits starting at base `p`.
  - Bits at or above `2*kmerLength` are zeroed; bits beyond the read width are also zero.
  - On `ready4Kmer`, go to WAIT_RESULT.
- **WAIT_RESULT.** Waits for `queryResultValid`.
  - Result 1: increment `numSolid`. If `runActive=0`, set `runStart=p` and `runActive=1`. If run length `p - runStart' + 1 > bestLen`, update `best = (runStart', p)`. Here `runStart'` is the run start after this update.
  - Result 0: `runActive=0`.
  - Then if `p == lastP`, go to OUT; otherwise `p++` and go to ISSUE.
- Ties: the first longest run wins, because the compare is strict `>`.
- **OUT.** `outValid=1`.
  - Island found: `startPosition=bestStart`, `endPosition=bestEnd + kmerLength - 1`, `islandFound=1`.
  - No island: `startPosition=0`, `endPosition=readLength-1`, `islandFound=0`.
  - On `ready4Island`, go to IDLE.
- `queryResultValid` outside WAIT_RESULT is ignored. So is `queryResultValid` in the same cycle as the ISSUE handshake.
- Arithmetic is unsigned at `MAX_READ_BIT_WIDTH`. `bestEnd + kmerLength - 1` never exceeds `readLength - 1`.

## Timing
- Reset: state IDLE. All outputs are 0 except `ready4Read=1`.
- `ready4Read`, `kmerValid` and `outValid` decode directly from the registered state; there is no combinational path from inputs.
- Accept at cycle 0 gives ISSUE at cycle 1.
- With `ready4Kmer=1` and result one cycle after the handshake, each k-mer takes 2 cycles. For N = `lastP+1` k-mers, `outValid` rises at cycle 2N+1.
- Short read (no queries): `outValid` at cycle 1.
- `kmer` and `kmerValid` hold stable while `ready4Kmer=0`.
- All OUT-state outputs hold stable while `ready4Island=0`.
- Only one query is outstanding at a time.
- Reset asserted mid-operation returns to IDLE immediately. The in-flight result is lost, and a late `queryResultValid` is ignored.

## Test plan
- `readLength=10`, `k=4`, results `0,1,1,1,0,1,0` → 7 queries, `start=1`, `end=6`, `islandFound=1`, `numSolid=4`, `outValid` at cycle 15.
- All-zero results, same read → `start=0`, `end=9`, `islandFound=0`, `numSolid=0`.
- Results `1,1,0,1,1,0,0` → tie resolved to the first run: `start=0`, `end=4`.
- `readLength=3`, `k=4` → no `kmerValid`, `outValid` at cycle 1, `start=0`, `end=2`, `islandFound=0`.
- Read bases 0..9 = `A,C,G,T,...`, `k=4` → `kmer` for `p=1` equals bases 1–4 packed at bits `[7:0]`, upper bits 0. Holding `ready4Kmer=0` for 5 cycles → `kmer` and `kmerValid` stay stable. Holding `ready4Island=0` → outputs stay stable, `ready4Read=0`.
- Assert `rstb` during WAIT_RESULT → next cycle `ready4Read=1`, `kmerValid=0`. A stray `queryResultValid` afterwards does not change `numSolid`.
